pdm_byte_streamer: RTL and testbench

- Capture stage between the PDM microphone and the AVR serial link.
- Samples `pdm_data` on each rising edge of the divided mic clock and packs 8 samples, MSB first, into a byte.
- Buffers the bytes in a small FIFO and drains them over the avr_interface tx handshake (`tx_data`/`new_tx_data`/`tx_busy`).
- Starts and stops streaming on single-byte commands received on the `rx_data`/`new_rx_data` path.

---
 rtl/pdm_stream_pkg.sv | 14 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/pdm_byte_streamer.sv | 135 +++++++++++++
 tb/tb_pdm_byte_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_stream_pkg.sv
// rtl/pdm_stream_pkg.sv - command bytes and TX FSM encoding for the PDM byte streamer
package pdm_stream_pkg;

  localparam logic [7:0] CMD_START = 8'h73;
  localparam logic [7:0] CMD_STOP  = 8'h78;
  localparam logic [7:0] CMD_CLEAR = 8'h63;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_SEND  = 2'd1;
  localparam tx_state_t TX_GUARD = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; push on full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pdm_byte_streamer.sv
// rtl/pdm_byte_streamer.sv - packs synchronized PDM samples into bytes and streams them over the avr tx handshake
module pdm_byte_streamer
  import pdm_stream_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pdm_clk,
  input  logic          pdm_data,
  output logic [7:0]    tx_data,
  output logic          new_tx_data,
  input  logic          tx_busy,
  input  logic [7:0]    rx_data,
  input  logic          new_rx_data,
  output logic          streaming,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_d;
  logic                   pdm_rise;
  logic                   pdm_bit;

  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_clear;
  logic [7:0] byte_val;
  logic       byte_push;

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  tx_state_t  state;

  // Clock and data share the same depth so the sampled bit lines up with the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_d     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], pdm_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], pdm_data};
      clk_d     <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign pdm_rise = clk_sync[SYNC_STAGES-1] & ~clk_d;
  assign pdm_bit  = data_sync[SYNC_STAGES-1];

  assign cmd_start = new_rx_data && (rx_data == CMD_START);
  assign cmd_stop  = new_rx_data && (rx_data == CMD_STOP);
  assign cmd_clear = new_rx_data && (rx_data == CMD_CLEAR);

  assign byte_val  = {shift[6:0], pdm_bit};
  // A start or stop in the same cycle as the eighth bit suppresses the push.
  assign byte_push = streaming & pdm_rise & (bit_cnt == 3'd7) & ~cmd_start & ~cmd_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streaming <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
    end else if (cmd_start) begin
      streaming <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
    end else if (cmd_stop) begin
      streaming <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
    end else if (streaming && pdm_rise) begin
      shift     <= byte_val;
      bit_cnt   <= bit_cnt + 3'd1;
    end
  end

  // A drop in the same cycle as a clear leaves the flag set so the loss is not hidden.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (byte_push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end else if (cmd_clear) begin
      overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_push),
    .pop   (fifo_pop),
    .din   (byte_val),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_pop    = (state == TX_IDLE) & ~fifo_empty & ~tx_busy;
  assign new_tx_data = (state == TX_SEND);

  // GUARD gives avr_interface one cycle to raise tx_busy before it is looked at again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= TX_IDLE;
      tx_data <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_data <= fifo_dout;
            state   <= TX_SEND;
          end
        end
        TX_SEND:  state <= TX_GUARD;
        TX_GUARD: state <= TX_IDLE;
        default:  state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_byte_streamer.sv
// tb/tb_pdm_byte_streamer.sv - randomized self-checking bench for pdm_byte_streamer against a byte-level model
module tb_pdm_byte_streamer;

  localparam int FIFO_DEPTH = 16;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pdm_clk = 1'b0;
  logic          pdm_data = 1'b0;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic          tx_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          new_rx_data = 1'b0;
  logic          streaming;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  pdm_byte_streamer #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pdm_clk     (pdm_clk),
    .pdm_data    (pdm_data),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .streaming   (streaming),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: bytes the link should carry, in order, plus capture state.
  logic [7:0] exp_q[$];
  logic [7:0] mon_q[$];
  bit         m_bits[$];
  bit         m_streaming = 1'b0;

  int   cyc = 0;
  int   last_strobe = -100;
  int   gap_viol = 0;
  int   busy_viol = 0;
  logic busy_last = 1'b0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    busy_last <= tx_busy;
  end

  always @(negedge clk) begin
    if (!rst && new_tx_data) begin
      mon_q.push_back(tx_data);
      if (cyc - last_strobe < 3) gap_viol++;
      if (busy_last) busy_viol++;
      last_strobe = cyc;
    end
  end

  task automatic model_cmd(input logic [7:0] c);
    if (c == 8'h73) begin m_streaming = 1'b1; m_bits.delete(); end
    else if (c == 8'h78) begin m_streaming = 1'b0; m_bits.delete(); end
  endtask

  task automatic model_bit(input bit b);
    int v;
    if (!m_streaming) return;
    m_bits.push_back(b);
    if (m_bits.size() == 8) begin
      v = 0;
      for (int i = 0; i < 8; i++) v = v * 2 + int'(m_bits[i]);
      m_bits.delete();
      if (exp_q.size() - mon_q.size() < FIFO_DEPTH) exp_q.push_back(8'(v));
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    rx_data = c;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    model_cmd(c);
  endtask

  task automatic pdm_bit(input bit b);
    pdm_data = b;
    pdm_clk = 1'b0;
    repeat (3) @(negedge clk);
    pdm_clk = 1'b1;
    repeat (4) @(negedge clk);
    model_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) pdm_bit(v[i]);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mon_q.size() == exp_q.size() && fifo_level == '0 && !new_tx_data) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (new_tx_data !== 1'b0) begin n_err++; $display("FAIL reset_new_tx_data: got %b want 0", new_tx_data); end
    n_cmp++; if (streaming !== 1'b0) begin n_err++; $display("FAIL reset_streaming: got %b want 0", streaming); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_start_pattern();
    bit ok;
    clear_queues();
    send_cmd(8'h73);
    n_cmp++; if (streaming !== 1'b1) begin n_err++; $display("FAIL start_streaming: got %b want 1", streaming); end
    send_byte(8'hB2);
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL start_drain: timed out, sent %0d want 1", mon_q.size()); end
    n_cmp++; if (mon_q.size() != 1) begin n_err++; $display("FAIL start_count: got %0d want 1", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== 8'hB2) begin n_err++; $display("FAIL start_byte: got %h want b2", mon_q[0]); end
    end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL start_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_random_bytes();
    bit ok;
    clear_queues();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int j = $urandom_range(1, 6); j > 0; j--) pdm_bit(1'($urandom_range(0, 1)));
        send_cmd(8'h73);
      end
      send_byte(8'($urandom_range(0, 255)));
    end
    wait_drain(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL random_drain: timed out, sent %0d want %0d", mon_q.size(), exp_q.size()); end
    n_cmp++; if (mon_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (mon_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_stop_mid_byte();
    bit ok;
    logic [7:0] r;
    clear_queues();
    send_cmd(8'h73);
    for (int j = 0; j < 5; j++) pdm_bit(1'($urandom_range(0, 1)));
    send_cmd(8'h78);
    for (int j = 0; j < 8; j++) pdm_bit(1'($urandom_range(0, 1)));
    repeat (20) @(negedge clk);
    n_cmp++; if (mon_q.size() != 0) begin n_err++; $display("FAIL stop_no_tx: got %0d strobes want 0", mon_q.size()); end
    n_cmp++; if (streaming !== 1'b0) begin n_err++; $display("FAIL stop_streaming: got %b want 0", streaming); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL stop_level: got %0d want 0", fifo_level); end
    r = 8'($urandom_range(0, 255));
    send_cmd(8'h73);
    send_byte(r);
    wait_drain(ok);
    n_cmp++; if (mon_q.size() != 1) begin n_err++; $display("FAIL stop_restart_count: got %0d want 1", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== r) begin n_err++; $display("FAIL stop_restart_byte: got %h want %h", mon_q[0], r); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int ff_cnt;
    clear_queues();
    tx_busy = 1'b1;
    for (int k = 0; k < 17; k++) send_byte(8'hFF);
    repeat (5) @(negedge clk);
    n_cmp++; if (fifo_level !== LW'(16)) begin n_err++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (mon_q.size() != 0) begin n_err++; $display("FAIL ovf_held: got %0d strobes want 0", mon_q.size()); end
    tx_busy = 1'b0;
    wait_drain(ok);
    ff_cnt = 0;
    foreach (mon_q[i]) if (mon_q[i] === 8'hFF) ff_cnt++;
    n_cmp++; if (mon_q.size() != 16) begin n_err++; $display("FAIL ovf_sent: got %0d want 16", mon_q.size()); end
    n_cmp++; if (ff_cnt != 16) begin n_err++; $display("FAIL ovf_values: got %0d ff bytes want 16", ff_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    send_cmd(8'h63);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int hold;
    clear_queues();
    tx_busy = 1'b1;
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    repeat (100) @(negedge clk);
    n_cmp++; if (mon_q.size() != 0) begin n_err++; $display("FAIL bp_held: got %0d strobes want 0", mon_q.size()); end
    n_cmp++; if (fifo_level !== LW'(2)) begin n_err++; $display("FAIL bp_level: got %0d want 2", fifo_level); end
    hold = 0;
    tx_busy = 1'b0;
    for (int i = 0; i < 300 && mon_q.size() < 2; i++) begin
      @(negedge clk);
      if (new_tx_data) hold = $urandom_range(1, 6);
      if (hold > 0) begin tx_busy = 1'b1; hold--; end
      else tx_busy = 1'b0;
    end
    tx_busy = 1'b0;
    wait_drain(ok);
    n_cmp++; if (mon_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d want %0d", mon_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (mon_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_byte[%0d]: got %h want %h", i, mon_q[i], exp_q[i]); end
      end
    end
    n_cmp++; if (gap_viol != 0) begin n_err++; $display("FAIL bp_gap: got %0d short gaps want 0", gap_viol); end
    n_cmp++; if (busy_viol != 0) begin n_err++; $display("FAIL bp_busy: got %0d strobes under busy want 0", busy_viol); end
  endtask

  task automatic test_collision();
    clear_queues();
    send_cmd(8'h73);
    for (int j = 0; j < 7; j++) pdm_bit(1'($urandom_range(0, 1)));
    pdm_data = 1'($urandom_range(0, 1));
    pdm_clk = 1'b0;
    repeat (3) @(negedge clk);
    pdm_clk = 1'b1;
    // Two flops of sync then the edge flop: the rise is seen at the third clock edge.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rx_data = 8'h78;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    model_cmd(8'h78);
    repeat (12) @(negedge clk);
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL coll_level: got %0d want 0", fifo_level); end
    n_cmp++; if (mon_q.size() != 0) begin n_err++; $display("FAIL coll_no_tx: got %0d strobes want 0", mon_q.size()); end
    n_cmp++; if (streaming !== 1'b0) begin n_err++; $display("FAIL coll_streaming: got %b want 0", streaming); end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen;
    logic [7:0] r;
    clear_queues();
    send_cmd(8'h73);
    tx_busy = 1'b1;
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    tx_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (new_tx_data) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL arst_send_seen: got no strobe want strobe"); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (new_tx_data !== 1'b0) begin n_err++; $display("FAIL arst_strobe: got %b want 0", new_tx_data); end
    n_cmp++; if (streaming !== 1'b0) begin n_err++; $display("FAIL arst_streaming: got %b want 0", streaming); end
    n_cmp++; if (fifo_level !== '0) begin n_err++; $display("FAIL arst_level: got %0d want 0", fifo_level); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_queues();
    m_streaming = 1'b0;
    m_bits.delete();
    @(negedge clk);
    r = 8'($urandom_range(0, 255));
    send_cmd(8'h73);
    send_byte(r);
    wait_drain(ok);
    n_cmp++; if (mon_q.size() != 1) begin n_err++; $display("FAIL arst_resume_count: got %0d want 1", mon_q.size()); end
    else begin
      n_cmp++; if (mon_q[0] !== r) begin n_err++; $display("FAIL arst_resume_byte: got %h want %h", mon_q[0], r); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_pattern();
    test_random_bytes();
    test_stop_mid_byte();
    test_overflow();
    test_back_to_back();
    test_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
